// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Package  : video_timing_pkg
// Desc     : Default 640x480@60 raster timing, test-pattern select encoding,
//            raster phase type and the colour-bar lookup table.
// Revision : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

    // Default 640x480@60 timing (800x525 total)
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // pat_sel encoding
    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_GRAD  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_FRAME = 2'd3;

    // Raster phase, shared by the horizontal and vertical sequencers
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    // Colour bars as {r,g,b} on/off bits, element 0 is the leftmost bar:
    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101,
        3'b010, 3'b011, 3'b110, 3'b111
    };

endpackage
`default_nettype wire

// File: rtl/video_pattern_lut.sv
`default_nettype none
// ============================================================================
// Module   : video_pattern_lut
// Desc     : Combinational map of (pattern, x, y, frame count) to RGB.
//            Blanking is applied by the caller.
// Revision : 1.0 - initial release
// ============================================================================
module video_pattern_lut
    import video_timing_pkg::*;
#(
    parameter int CW       = 8,
    parameter int CNTW     = 12,
    parameter int H_ACTIVE = DEF_H_ACTIVE
)(
    input  logic [1:0]      i_pat,
    input  logic [CNTW-1:0] i_x,
    input  logic [CNTW-1:0] i_y,
    input  logic [CW-1:0]   i_frame_cnt,
    output logic [CW-1:0]   o_r,
    output logic [CW-1:0]   o_g,
    output logic [CW-1:0]   o_b
);

    localparam logic [CNTW-1:0] c_bar_w = CNTW'(H_ACTIVE / 8);

    logic [CNTW-1:0] w_bar_full;
    logic [2:0]      w_bar_idx;
    logic [2:0]      w_bar_rgb;
    logic            w_check;
    logic            w_unused_bits;

    // Bar index is only meaningful inside the active width (0..7)
    assign w_bar_full    = i_x / c_bar_w;
    assign w_bar_idx     = w_bar_full[2:0];
    assign w_bar_rgb     = BAR_RGB[w_bar_idx];
    assign w_check       = i_x[5] ^ i_y[5];
    assign w_unused_bits = ^{w_bar_full[CNTW-1:3], i_y[CNTW-1:6], i_y[4:0]};

    // Pattern select
    always_comb begin
        o_r = '0;
        o_g = '0;
        o_b = '0;
        case (i_pat)
            PAT_BARS: begin
                o_r = {CW{w_bar_rgb[2]}};
                o_g = {CW{w_bar_rgb[1]}};
                o_b = {CW{w_bar_rgb[0]}};
            end
            PAT_GRAD: begin
                o_r = i_x[CW-1:0];
                o_g = i_x[CW-1:0];
                o_b = i_x[CW-1:0];
            end
            PAT_CHECK: begin
                o_r = {CW{w_check}};
                o_g = {CW{w_check}};
                o_b = {CW{w_check}};
            end
            PAT_FRAME: begin
                o_r = i_frame_cnt;
                o_g = ~i_frame_cnt;
            end
            default: begin
                o_r = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_pattern_gen
// Desc     : Raster timing generator with h/v sync, active qualifier and a
//            selectable RGB test pattern. Outputs are registered and lag the
//            raster counters by one enabled cycle.
// Options  : VIDEO_PATTERN_GEN_TESTPAT_EN - when defined the pattern path,
//            pattern latch and frame counter are built; otherwise RGB is 0.
// Revision : 1.0 - initial release
// ============================================================================
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int   CW       = 8,
    parameter int   CNTW     = 12,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0
)(
    input  logic            vid_clk,
    input  logic            vid_rst_n,
    input  logic            vid_clk_en,
    input  logic [1:0]      pat_sel,
    output logic            vid_active,
    output logic            vid_hsync,
    output logic            vid_vsync,
    output logic            vid_frame_start,
    output logic [CNTW-1:0] vid_x,
    output logic [CNTW-1:0] vid_y,
    output logic [CW-1:0]   vid_r,
    output logic [CW-1:0]   vid_g,
    output logic [CW-1:0]   vid_b
);

    // Last count value of each phase
    localparam logic [CNTW-1:0] c_h_act_last  = CNTW'(H_ACTIVE - 1);
    localparam logic [CNTW-1:0] c_h_fp_last   = CNTW'(H_ACTIVE + H_FP - 1);
    localparam logic [CNTW-1:0] c_h_sync_last = CNTW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNTW-1:0] c_h_last      = CNTW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNTW-1:0] c_v_act_last  = CNTW'(V_ACTIVE - 1);
    localparam logic [CNTW-1:0] c_v_fp_last   = CNTW'(V_ACTIVE + V_FP - 1);
    localparam logic [CNTW-1:0] c_v_sync_last = CNTW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNTW-1:0] c_v_last      = CNTW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [CNTW-1:0] r_h_cnt_q, w_h_cnt_d;
    logic [CNTW-1:0] r_v_cnt_q, w_v_cnt_d;
    phase_e          r_h_phase_q, w_h_phase_d;
    phase_e          r_v_phase_q, w_v_phase_d;
    logic            w_h_wrap, w_v_wrap, w_origin;

    logic            r_active_q, w_active_d;
    logic            r_hsync_q, w_hsync_d;
    logic            r_vsync_q, w_vsync_d;
    logic            r_fs_q, w_fs_d;
    logic [CW-1:0]   r_r_q, w_r_d;
    logic [CW-1:0]   r_g_q, w_g_d;
    logic [CW-1:0]   r_b_q, w_b_d;
    logic [CNTW-1:0] r_x_q, r_y_q;
    logic [CW-1:0]   w_pix_r, w_pix_g, w_pix_b;

    assign w_origin = (r_h_cnt_q == '0) && (r_v_cnt_q == '0);

    // Next raster position: v advances on h wrap, both return to 0 at frame end
    always_comb begin
        w_h_wrap  = (r_h_cnt_q == c_h_last);
        w_v_wrap  = (r_v_cnt_q == c_v_last);
        w_h_cnt_d = w_h_wrap ? '0 : r_h_cnt_q + CNTW'(1);
        w_v_cnt_d = r_v_cnt_q;
        if (w_h_wrap) begin
            w_v_cnt_d = w_v_wrap ? '0 : r_v_cnt_q + CNTW'(1);
        end
    end

    // Horizontal phase sequencer: phase tracks the current h_cnt
    always_comb begin
        w_h_phase_d = r_h_phase_q;
        case (r_h_phase_q)
            PH_ACTIVE: if (r_h_cnt_q == c_h_act_last)  w_h_phase_d = PH_FP;
            PH_FP:     if (r_h_cnt_q == c_h_fp_last)   w_h_phase_d = PH_SYNC;
            PH_SYNC:   if (r_h_cnt_q == c_h_sync_last) w_h_phase_d = PH_BP;
            PH_BP:     if (r_h_cnt_q == c_h_last)      w_h_phase_d = PH_ACTIVE;
            default:                                   w_h_phase_d = PH_ACTIVE;
        endcase
    end

    // Vertical phase sequencer: same ordering, stepped once per line
    always_comb begin
        w_v_phase_d = r_v_phase_q;
        if (w_h_wrap) begin
            case (r_v_phase_q)
                PH_ACTIVE: if (r_v_cnt_q == c_v_act_last)  w_v_phase_d = PH_FP;
                PH_FP:     if (r_v_cnt_q == c_v_fp_last)   w_v_phase_d = PH_SYNC;
                PH_SYNC:   if (r_v_cnt_q == c_v_sync_last) w_v_phase_d = PH_BP;
                PH_BP:     if (r_v_cnt_q == c_v_last)      w_v_phase_d = PH_ACTIVE;
                default:                                   w_v_phase_d = PH_ACTIVE;
            endcase
        end
    end

`ifdef VIDEO_PATTERN_GEN_TESTPAT_EN
    logic [1:0]    r_pat_q, w_pat_d, w_pat_eff;
    logic [CW-1:0] r_frame_cnt_q, w_frame_cnt_d;

    // Pattern is sampled at the frame origin; pixel (0,0) already uses the new one
    always_comb begin
        w_pat_eff     = w_origin ? pat_sel : r_pat_q;
        w_pat_d       = w_pat_eff;
        w_frame_cnt_d = (w_h_wrap && w_v_wrap) ? r_frame_cnt_q + CW'(1) : r_frame_cnt_q;
    end

    // Pattern latch and frame counter
    always_ff @(posedge vid_clk) begin
        if (!vid_rst_n) begin
            r_pat_q       <= PAT_BARS;
            r_frame_cnt_q <= '0;
        end else if (vid_clk_en) begin
            r_pat_q       <= w_pat_d;
            r_frame_cnt_q <= w_frame_cnt_d;
        end
    end

    video_pattern_lut #(
        .CW       (CW),
        .CNTW     (CNTW),
        .H_ACTIVE (H_ACTIVE)
    ) u_lut (
        .i_pat       (w_pat_eff),
        .i_x         (r_h_cnt_q),
        .i_y         (r_v_cnt_q),
        .i_frame_cnt (r_frame_cnt_q),
        .o_r         (w_pix_r),
        .o_g         (w_pix_g),
        .o_b         (w_pix_b)
    );
`else
    logic w_unused_pat_sel;

    assign w_unused_pat_sel = ^pat_sel;
    assign w_pix_r          = '0;
    assign w_pix_g          = '0;
    assign w_pix_b          = '0;
`endif

    // Output values for the current raster position, blanked outside active
    always_comb begin
        w_active_d = (r_h_phase_q == PH_ACTIVE) && (r_v_phase_q == PH_ACTIVE);
        w_hsync_d  = (r_h_phase_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        w_vsync_d  = (r_v_phase_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        w_fs_d     = w_origin;
        w_r_d      = w_active_d ? w_pix_r : '0;
        w_g_d      = w_active_d ? w_pix_g : '0;
        w_b_d      = w_active_d ? w_pix_b : '0;
    end

    // Counters, phases and output registers; reset wins over the pixel enable
    always_ff @(posedge vid_clk) begin
        if (!vid_rst_n) begin
            r_h_cnt_q   <= '0;
            r_v_cnt_q   <= '0;
            r_h_phase_q <= PH_ACTIVE;
            r_v_phase_q <= PH_ACTIVE;
            r_active_q  <= 1'b0;
            r_hsync_q   <= ~SYNC_POL;
            r_vsync_q   <= ~SYNC_POL;
            r_fs_q      <= 1'b0;
            r_x_q       <= '0;
            r_y_q       <= '0;
            r_r_q       <= '0;
            r_g_q       <= '0;
            r_b_q       <= '0;
        end else if (vid_clk_en) begin
            r_h_cnt_q   <= w_h_cnt_d;
            r_v_cnt_q   <= w_v_cnt_d;
            r_h_phase_q <= w_h_phase_d;
            r_v_phase_q <= w_v_phase_d;
            r_active_q  <= w_active_d;
            r_hsync_q   <= w_hsync_d;
            r_vsync_q   <= w_vsync_d;
            r_fs_q      <= w_fs_d;
            r_x_q       <= r_h_cnt_q;
            r_y_q       <= r_v_cnt_q;
            r_r_q       <= w_r_d;
            r_g_q       <= w_g_d;
            r_b_q       <= w_b_d;
        end
    end

    assign vid_active      = r_active_q;
    assign vid_hsync       = r_hsync_q;
    assign vid_vsync       = r_vsync_q;
    assign vid_frame_start = r_fs_q;
    assign vid_x           = r_x_q;
    assign vid_y           = r_y_q;
    assign vid_r           = r_r_q;
    assign vid_g           = r_g_q;
    assign vid_b           = r_b_q;

endmodule
`default_nettype wire
